// File: rtl/spi_bus_peripheral.sv
// Memory-mapped SPI master: bus-decoded TX/RX/CTRL/DIV registers driving a
// single-byte, MSB-first shifter with programmable half-period divider.
module spi_bus_peripheral #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  write_mask,
    output logic [31:0] data_out,
    input  logic        bus_enable,
    input  logic        write_enable,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs
);

    typedef enum logic [1:0] {REG_TX, REG_RX, REG_CTRL, REG_DIV} reg_sel_e;
    typedef enum logic [1:0] {IDLE, LEAD, TRAIL, DONE} state_e;

    state_e                 state, state_nx;
    reg_sel_e               reg_sel;
    logic                   bus_en_q;
    logic                   access_evt, wr_evt, rd_evt, lane0_wr;
    logic                   tx_wr_evt, rx_rd_evt, ctrl_wr_evt, div_wr_evt;
    logic                   busy, start, lead_edge, trail_edge, done_evt;
    logic [DIV_WIDTH-1:0]   div, half_cnt;
    logic                   half_zero;
    logic [2:0]             bit_cnt;
    logic [7:0]             shifter, tx_byte, rx_byte;
    logic                   rx_valid, overrun, cpol, cs_en;
    logic                   unused_bits;

    assign reg_sel = reg_sel_e'(address[3:2]);

    // An access is the first cycle of a bus_enable pulse, however long it stays high.
    assign access_evt  = bus_enable & ~bus_en_q;
    assign wr_evt      = access_evt & write_enable;
    assign rd_evt      = access_evt & ~write_enable;
    assign lane0_wr    = wr_evt & ~write_mask[0];
    assign tx_wr_evt   = lane0_wr && (reg_sel == REG_TX);
    assign ctrl_wr_evt = lane0_wr && (reg_sel == REG_CTRL);
    assign div_wr_evt  = lane0_wr && (reg_sel == REG_DIV);
    assign rx_rd_evt   = rd_evt && (reg_sel == REG_RX);

    assign half_zero   = (half_cnt == '0);
    assign spi_cs      = ~cs_en;
    assign unused_bits = ^{address[1:0], data_in[31:8], write_mask[3:1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bus_en_q <= 1'b0;
        end else begin
            state    <= state_nx;
            bus_en_q <= bus_enable;
        end
    end

    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (tx_wr_evt) state_nx = LEAD;
            LEAD:  if (half_zero) state_nx = TRAIL;
            TRAIL: if (half_zero) state_nx = (bit_cnt == 3'd7) ? DONE : LEAD;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        start      = (state == IDLE) && tx_wr_evt;
        lead_edge  = (state == LEAD) && half_zero;
        trail_edge = (state == TRAIL) && half_zero;
        done_evt   = (state == DONE);
    end

    // Shift datapath: MISO enters at the leading edge, next MOSI bit leaves at the trailing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            tx_byte  <= '0;
            rx_byte  <= '0;
            spi_mosi <= 1'b0;
            spi_clk  <= 1'b0;
        end else begin
            if (start) begin
                tx_byte  <= data_in[7:0];
                shifter  <= data_in[7:0];
                spi_mosi <= data_in[7];
                bit_cnt  <= '0;
                half_cnt <= div;
            end else if (lead_edge || trail_edge) begin
                half_cnt <= div;
            end else if (state == LEAD || state == TRAIL) begin
                half_cnt <= half_cnt - 1'b1;
            end

            if (lead_edge)
                shifter <= {shifter[6:0], spi_miso};

            if (trail_edge && bit_cnt != 3'd7) begin
                spi_mosi <= shifter[7];
                bit_cnt  <= bit_cnt + 1'b1;
            end

            if (state == IDLE)
                spi_clk <= cpol;
            else if (lead_edge)
                spi_clk <= ~cpol;
            else if (trail_edge)
                spi_clk <= cpol;

            if (done_evt)
                rx_byte <= shifter;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            cpol     <= 1'b0;
            cs_en    <= 1'b0;
            div      <= DIV_WIDTH'(DEFAULT_DIV);
        end else begin
            // Completion beats a coincident RX read so a fresh byte is never lost.
            if (done_evt)
                rx_valid <= 1'b1;
            else if (rx_rd_evt)
                rx_valid <= 1'b0;

            if (done_evt && rx_valid && !rx_rd_evt)
                overrun <= 1'b1;
            else if (ctrl_wr_evt && data_in[4])
                overrun <= 1'b0;

            if (ctrl_wr_evt) begin
                cpol  <= data_in[2];
                cs_en <= data_in[3];
            end

            if (div_wr_evt)
                div <= data_in[DIV_WIDTH-1:0];
        end
    end

    always_comb begin
        data_out = '0;
        if (bus_enable) begin
            unique case (reg_sel)
                REG_TX:   data_out = {24'd0, tx_byte};
                REG_RX:   data_out = {24'd0, rx_byte};
                REG_CTRL: data_out = {27'd0, overrun, cs_en, cpol, rx_valid, busy};
                REG_DIV:  data_out = {{(32-DIV_WIDTH){1'b0}}, div};
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_peripheral.sv
// Bench for spi_bus_peripheral: directed bus traffic, read expectations queued
// for a negedge monitor, pin behaviour checked inline.
module tb_spi_bus_peripheral;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic [31:0] data_in;
    logic [3:0]  write_mask;
    logic [31:0] data_out;
    logic        bus_enable;
    logic        write_enable;
    logic        spi_clk, spi_mosi, spi_miso, spi_cs;
    logic        loop_en, miso_drv;

    assign spi_miso = loop_en ? spi_mosi : miso_drv;

    always #5 clk = ~clk;

    spi_bus_peripheral #(.DIV_WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .write_mask   (write_mask),
        .data_out     (data_out),
        .bus_enable   (bus_enable),
        .write_enable (write_enable),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_cs       (spi_cs)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        scored_rd = 1'b0;
    logic        cap_en = 1'b0;
    logic [7:0]  cap;
    int          cap_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: the CPU samples data_out in the cycle it raises bus_enable.
    always @(negedge clk) begin
        if (scored_rd) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rd_unexpected: got 0x%08h with no expectation queued", data_out);
            end else begin
                check(name_q.pop_front(), data_out, exp_q.pop_front());
            end
        end
    end

    always @(posedge spi_clk) begin
        if (cap_en) begin
            cap   <= {cap[6:0], spi_mosi};
            cap_n <= cap_n + 1;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        @(posedge clk); #1;
        bus_enable = 1'b1; write_enable = 1'b1; address = a; data_in = d; write_mask = m;
        @(posedge clk); #1;
        bus_enable = 1'b0; write_enable = 1'b0; write_mask = 4'hF;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        scored_rd = 1'b1; bus_enable = 1'b1; write_enable = 1'b0; address = a;
        @(posedge clk); #1;
        scored_rd = 1'b0; bus_enable = 1'b0;
    endtask

    // Start a TX transfer then poll CTRL.busy each cycle; optionally inject a TX write mid-transfer.
    task automatic xfer(input logic [7:0] d, input bit inject, output int busy_n, output int toggles);
        logic prev;
        @(posedge clk); #1;
        bus_enable = 1'b1; write_enable = 1'b1; address = 4'h0; data_in = {24'd0, d}; write_mask = 4'hE;
        @(posedge clk); #1;
        write_enable = 1'b0; address = 4'h8; write_mask = 4'hF;
        prev = spi_clk; busy_n = -1; toggles = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (spi_clk !== prev) toggles++;
            prev = spi_clk;
            if (bus_enable && !write_enable && address == 4'h8 && data_out[0] == 1'b0) begin
                busy_n = cyc - 1;
                break;
            end
            if (inject) begin
                case (cyc)
                    8:  bus_enable = 1'b0;
                    9:  begin
                        bus_enable = 1'b1; write_enable = 1'b1; address = 4'h0;
                        data_in = 32'h3C; write_mask = 4'hE;
                    end
                    10: begin write_enable = 1'b0; address = 4'h8; write_mask = 4'hF; end
                    default: ;
                endcase
            end
        end
        bus_enable = 1'b0; write_enable = 1'b0;
        if (busy_n < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL xfer_timeout: busy never cleared within 300 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, toggles, rises;
        logic prev;

        reset = 1'b1; address = '0; data_in = '0; write_mask = 4'hF;
        bus_enable = 1'b0; write_enable = 1'b0; loop_en = 1'b1; miso_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_spi_cs", {31'd0, spi_cs}, 32'd1);
        check("rst_spi_clk", {31'd0, spi_clk}, 32'd0);
        check("rst_spi_mosi", {31'd0, spi_mosi}, 32'd0);
        address = 4'h8;
        #1 check("idle_data_out", data_out, 32'd0);
        bus_read(4'h0, 32'h00, "rst_tx");
        bus_read(4'h4, 32'h00, "rst_rx");
        bus_read(4'h8, 32'h00, "rst_ctrl");
        bus_read(4'hC, 32'h04, "rst_div");

        // DIV=1, cs_en=1, loopback transfer of 0xA5 with an ignored TX write mid-flight
        bus_write(4'hC, 32'h01, 4'hE);
        bus_write(4'h8, 32'h08, 4'hE);
        check("cs_asserted", {31'd0, spi_cs}, 32'd0);
        cap_en = 1'b1; cap = '0; cap_n = 0;
        xfer(8'hA5, 1'b1, busy_n, toggles);
        cap_en = 1'b0;
        check("a5_busy_cycles", busy_n, 33);
        check("a5_clk_toggles", toggles, 16);
        check("a5_mosi_bits", {24'd0, cap}, 32'hA5);
        check("a5_rise_count", cap_n, 8);
        bus_read(4'h0, 32'hA5, "tx_after_ignored_write");
        bus_read(4'h8, 32'h0A, "ctrl_after_a5");
        bus_read(4'h4, 32'hA5, "rx_a5");

        // Two transfers without an RX read -> overrun
        xfer(8'h5A, 1'b0, busy_n, toggles);
        check("ovr1_busy_cycles", busy_n, 33);
        xfer(8'h5A, 1'b0, busy_n, toggles);
        check("ovr2_busy_cycles", busy_n, 33);
        bus_read(4'h8, 32'h1A, "ctrl_overrun_set");
        bus_write(4'h8, 32'h18, 4'hE);
        bus_read(4'h8, 32'h0A, "ctrl_overrun_cleared");
        bus_read(4'h4, 32'h5A, "rx_5a");

        // cpol=1, DIV=0, TX=0xFF with MISO held low
        loop_en = 1'b0; miso_drv = 1'b0;
        bus_write(4'hC, 32'h00, 4'hE);
        bus_write(4'h8, 32'h0C, 4'hE);
        repeat (2) @(posedge clk);
        #1 check("cpol1_idle_clk", {31'd0, spi_clk}, 32'd1);
        xfer(8'hFF, 1'b0, busy_n, toggles);
        check("ff_busy_cycles", busy_n, 17);
        check("ff_clk_toggles", toggles, 16);
        check("cpol1_clk_after", {31'd0, spi_clk}, 32'd1);
        bus_read(4'h4, 32'h00, "rx_ff_miso0");

        // Reset in the middle of the fourth bit
        loop_en = 1'b1;
        bus_write(4'h8, 32'h08, 4'hE);
        bus_write(4'hC, 32'h01, 4'hE);
        bus_write(4'h0, 32'hC3, 4'hE);
        prev = spi_clk; rises = 0;
        for (int i = 0; i < 200 && rises < 4; i++) begin
            @(negedge clk);
            if (spi_clk && !prev) rises++;
            prev = spi_clk;
        end
        check("rst_mid_rises", rises, 4);
        address = 4'h8; write_enable = 1'b0; bus_enable = 1'b1;
        #1 check("rst_mid_pre_busy", {31'd0, data_out[0]}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_spi_clk", {31'd0, spi_clk}, 32'd0);
        check("rst_mid_spi_cs", {31'd0, spi_cs}, 32'd1);
        check("rst_mid_ctrl", data_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; bus_enable = 1'b0;
        bus_read(4'hC, 32'h04, "rst_mid_div");
        bus_read(4'h8, 32'h00, "rst_mid_ctrl_after");
        bus_read(4'h0, 32'h00, "rst_mid_tx");

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_bus_peripheral.md
Name: spi_bus_peripheral

Overview:
Memory-mapped SPI master peripheral that acts as a responder on the CPU memory bus. It decodes bus read and write cycles from the core and drives the external spi_clk, spi_mosi and spi_cs pins. It sits behind memory_bus's peripheral decode, which forwards the word-aligned local offset. It shifts one byte per transfer, MSB first, and reports its status through a register.

Parameters:
DIV_WIDTH, 8, width of the clock divider register
DEFAULT_DIV, 4, divider reset value; half SPI period = (DIV+1) clk cycles

Ports:
clk  input  1  system clock (CPU clock)
reset  input  1  asynchronous, active-high reset
address  input  4  local byte offset; [3:2] selects register, [1:0] ignored
data_in  input  32  write data from CPU
write_mask  input  4  per-byte write mask, active low (0 = write that byte lane)
data_out  output  32  read data
bus_enable  input  1  bus cycle active
write_enable  input  1  cycle is a write (qualified by bus_enable)
spi_clk  output  1  SPI clock
spi_mosi  output  1  SPI data out
spi_miso  input  1  SPI data in
spi_cs  output  1  chip select, active low, software controlled

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high.
- Register map:
  - 0x0 TX: a write to lane 0 starts a transfer of data_in[7:0]. Reads return the last TX byte.
  - 0x4 RX: read returns {24'b0, rx_byte}.
  - 0x8 CTRL:
    - bit0 busy, read-only.
    - bit1 rx_valid, read-only.
    - bit2 cpol, read/write.
    - bit3 cs_en, read/write; spi_cs = ~cs_en.
    - bit4 overrun, sticky; writing 1 to it clears it.
  - 0xC DIV: [DIV_WIDTH-1:0], read/write.
- Reset values:
  - spi_cs=1, spi_clk=0, spi_mosi=0.
  - TX=0, RX=0, cpol=0, cs_en=0, rx_valid=0, overrun=0.
  - DIV=DEFAULT_DIV, state IDLE.
- Reads:
  - data_out is combinational from address[3:2] while bus_enable=1; it is 0 when bus_enable=0.
  - The CPU samples data_out on the clk edge after it raises bus_enable.
- Access event detection:
  - Accesses are detected on the rising edge of bus_enable, using a registered copy of bus_enable.
  - Each access is acted on exactly once, even if bus_enable stays high for multiple cycles.
- Read side effect: an RX read event clears rx_valid. If DONE occurs in the same cycle, DONE wins and rx_valid stays 1.
- Writes:
  - Apply only to lanes with write_mask bit = 0.
  - CTRL and DIV use lane 0 only.
- TX write rules:
  - A TX write while busy is ignored entirely; TX, state and overrun are unchanged.
  - A DIV write while busy takes effect at the next half-period reload.
- State machine: IDLE, LEAD, TRAIL, DONE.
  - IDLE:
    - spi_clk = cpol.
    - On a TX write event: load shifter and TX, drive spi_mosi=bit7, bit_cnt=0, load half counter with DIV.
    - Go to LEAD; busy=1 from the next cycle.
  - LEAD:
    - Count down the half counter.
    - At 0: spi_clk <= ~cpol, sample spi_miso into shifter LSB, reload the counter, go to TRAIL.
  - TRAIL:
    - At counter 0: spi_clk <= cpol, reload the counter.
    - If bit_cnt==7, go to DONE.
    - Otherwise shift, drive the next MSB on spi_mosi, bit_cnt++, go to LEAD.
  - DONE (1 cycle):
    - rx_byte <= shifter.
    - If rx_valid was already 1 and no RX read occurs this cycle, set overrun.
    - rx_valid <= 1; go to IDLE; busy clears.
- Timing:
  - Busy duration = 16*(DIV+1)+1 cycles.
  - DIV=0 gives spi_clk period = 2 clk cycles.
- Chip select:
  - spi_cs is independent of the state machine.
  - Changing cs_en or cpol mid-transfer is allowed but undefined on the wire. cpol takes effect at the next edge.
- Reset mid-transfer: all state returns to reset values immediately (asynchronously); spi_clk returns to 0 and spi_cs to 1.

Test Plan:
- Reset, then read each register with bus_enable=1 -> TX=0, RX=0, CTRL=0, DIV=4. With bus_enable=0, data_out=0.
- DIV=1, cpol=0, cs_en=1, write TX=0xA5, miso looped to mosi -> spi_cs=0. MOSI bits 1,0,1,0,0,1,0,1 on 8 rising edges. Busy for 33 cycles, then RX=0xA5, CTRL=0x0A.
- Write TX=0x3C during the previous transfer -> ignored; TX still 0xA5 and the transfer completes unchanged.
- Complete two transfers without reading RX -> CTRL bit4=1. Write CTRL=0x18 -> overrun cleared, cs_en kept.
- cpol=1, DIV=0, TX=0xFF, miso=0 -> spi_clk idles 1 with period 2 cycles. RX=0x00 after 17 busy cycles.
- Assert reset after 3 bits of a transfer -> spi_clk=0, spi_cs=1 and busy=0 immediately. DIV=4, rx_valid=0.
